// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the 4-bit registered ALU
//
// Purpose: datapath width and the 2-bit opcode encoding {OP1,OP0}.
// Ports:   none (package).
package alu_pkg;

   localparam int WIDTH = 4;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

endpackage

// File: rtl/alu_adder4.sv
// rtl/alu_adder4.sv - 4-bit ripple-carry adder with carry-out and signed overflow
//
// Purpose: sum = a + b + cin, shared by ADD, SUB and INC in the ALU.
// Ports:
//   a, b  [3:0] in   addends
//   cin         in   carry into bit 0
//   sum   [3:0] out  modulo-16 sum
//   cout        out  carry out of bit 3
//   ovf         out  two's-complement overflow (same-sign addends, sum sign differs)
module alu_adder4
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // Carry kept as a procedural variable so the ripple chain is evaluated
   // in order inside one block rather than as a combinational feedback vector.
   logic carry;

   always_comb begin
      sum   = '0;
      carry = cin;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
      ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 4-bit registered ALU: ADD/SUB with carry, INC, PASS
//
// Purpose: one-cycle-latency ALU; result and flags registered on in_valid.
// Ports:
//   clk, rst_n        in   rising-edge clock, asynchronous active-low reset
//   A, B      [3:0]   in   operands
//   CIN               in   carry-in (ADD) / borrow-in (SUB)
//   OP1, OP0          in   opcode {OP1,OP0}: 00 ADD, 01 SUB, 10 INC, 11 PASS
//   in_valid          in   capture operation at this edge
//   S         [3:0]   out  registered result
//   CF, OF            out  registered carry / signed-overflow flags
//   out_valid         out  high for the one cycle after a capture
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             OP1,
   input  logic             OP0,
   input  logic             in_valid,
   output logic [WIDTH-1:0] S,
   output logic             CF,
   output logic             OF,
   output logic             out_valid
);

   logic [1:0]       op;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             add_ovf;

   logic [WIDTH-1:0] res_s;
   logic             res_cf;
   logic             res_of;

   logic [WIDTH-1:0] s_d, s_q;
   logic             cf_d, cf_q;
   logic             of_d, of_q;
   logic             valid_d, valid_q;

   assign op = {OP1, OP0};

   alu_adder4 u_adder (
      .a    (A),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout),
      .ovf  (add_ovf)
   );

   // B and CIN only reach the adder for ADD/SUB, so unknowns on them in
   // INC/PASS cannot leak into the result.
   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      res_s   = A;
      res_cf  = 1'b0;
      res_of  = 1'b0;
      case (op)
         OP_ADD: begin
            add_b   = B;
            add_cin = CIN;
            res_s   = add_sum;
            res_cf  = add_cout;
            res_of  = add_ovf;
         end
         OP_SUB: begin
            // A - B - CIN == A + ~B + !CIN; carry-out 1 means no borrow.
            add_b   = ~B;
            add_cin = ~CIN;
            res_s   = add_sum;
            res_cf  = add_cout;
            res_of  = add_ovf;
         end
         OP_INC: begin
            add_b   = '0;
            add_cin = 1'b1;
            res_s   = add_sum;
            res_cf  = add_cout;
            res_of  = add_ovf;
         end
         default: begin
            res_s  = A;
            res_cf = 1'b0;
            res_of = 1'b0;
         end
      endcase
   end

   always_comb begin
      s_d     = s_q;
      cf_d    = cf_q;
      of_d    = of_q;
      valid_d = in_valid;
      if (in_valid) begin
         s_d  = res_s;
         cf_d = res_cf;
         of_d = res_of;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= '0;
         cf_q    <= 1'b0;
         of_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         cf_q    <= cf_d;
         of_q    <= of_d;
         valid_q <= valid_d;
      end
   end

   assign S         = s_q;
   assign CF        = cf_q;
   assign OF        = of_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard testbench for alu
module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [3:0] A, B;
   logic       CIN, OP1, OP0, in_valid;
   logic [3:0] S;
   logic       CF, OF, out_valid;

   int n_checks;
   int n_fails;

   logic [5:0] exp_q[$];   // {OF, CF, S}
   logic [5:0] last_exp;
   logic       cap;

   alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .CIN       (CIN),
      .OP1       (OP1),
      .OP0       (OP0),
      .in_valid  (in_valid),
      .S         (S),
      .CF        (CF),
      .OF        (OF),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model in signed/unsigned integer arithmetic.
   function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [1:0] op);
      int ua, ub, uc, sa, sb, u, r;
      logic cf, of;
      ua = int'(a);
      ub = int'(b);
      uc = cin ? 1 : 0;
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      case (op)
         2'b00: begin
            u  = ua + ub + uc;
            r  = sa + sb + uc;
            cf = (u > 15);
            of = (r > 7) || (r < -8);
         end
         2'b01: begin
            u  = ua - ub - uc;
            r  = sa - sb - uc;
            cf = (u >= 0);
            of = (r > 7) || (r < -8);
         end
         2'b10: begin
            u  = ua + 1;
            r  = sa + 1;
            cf = (u > 15);
            of = (r > 7);
         end
         default: begin
            u  = ua;
            cf = 1'b0;
            of = 1'b0;
         end
      endcase
      return {of, cf, 4'(u & 15)};
   endfunction

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [1:0] op);
      logic [5:0] e;
      @(negedge clk);
      A        = a;
      B        = b;
      CIN      = cin;
      {OP1, OP0} = op;
      in_valid = 1'b1;
      e = model(a, (op[1] ? 4'b0000 : b), (op[1] ? 1'b0 : cin), op);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Scoreboard: note captures at each rising edge, compare at the falling edge.
   always @(posedge clk) cap <= in_valid && rst_n;

   always @(negedge clk) begin
      logic [5:0] e;
      check("out_valid", {7'd0, out_valid}, {7'd0, cap});
      if (cap) begin
         if (exp_q.size() == 0) begin
            check("queue_underflow", 8'd1, 8'd0);
         end else begin
            e = exp_q.pop_front();
            last_exp = e;
         end
      end
      check("S",  {4'd0, S},  {4'd0, last_exp[3:0]});
      check("CF", {7'd0, CF}, {7'd0, last_exp[4]});
      check("OF", {7'd0, OF}, {7'd0, last_exp[5]});
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      last_exp = '0;
      cap      = 1'b0;
      rst_n    = 1'b0;
      A = '0; B = '0; CIN = 1'b0; OP1 = 1'b0; OP0 = 1'b0; in_valid = 1'b0;
      #1;
      check("reset_S", {4'd0, S}, 8'd0);
      check("reset_out_valid", {7'd0, out_valid}, 8'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed cases.
      drive(4'b0011, 4'b0101, 1'b0, 2'b00);
      drive(4'b1111, 4'b0001, 1'b1, 2'b00);
      drive(4'b1000, 4'b0010, 1'b0, 2'b01);
      drive(4'b0010, 4'b0011, 1'b1, 2'b01);
      drive(4'b1111, 4'b0000, 1'b0, 2'b10);
      drive(4'b0111, 4'bxxxx, 1'bx, 2'b10);
      drive(4'b1010, 4'bxxxx, 1'bx, 2'b11);
      idle(4);

      // Random stimulus with gaps in in_valid.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0)
            idle(1);
         else
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      idle(2);

      // Asynchronous reset between edges after a valid op.
      drive(4'b0110, 4'b0011, 1'b1, 2'b00);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_S", {4'd0, S}, 8'd0);
      check("async_rst_CF", {7'd0, CF}, 8'd0);
      check("async_rst_OF", {7'd0, OF}, 8'd0);
      check("async_rst_out_valid", {7'd0, out_valid}, 8'd0);
      last_exp = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      drive(4'b0100, 4'b0100, 1'b0, 2'b00);
      drive(4'b1001, 4'b0001, 1'b0, 2'b11);
      idle(3);
      check("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit registered arithmetic/logic unit.
- Ops: add with carry-in, subtract with borrow-in, increment, pass-through.
- Produces a 4-bit result plus carry (CF) and signed-overflow (OF) flags.
- Leaf datapath block. One clock, asynchronous active-low reset, all outputs registered, one-cycle latency.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  4  operand A (two's complement when interpreted signed)
- B  input  4  operand B
- CIN  input  1  carry-in for add; borrow-in for subtract; ignored otherwise
- OP1  input  1  opcode MSB
- OP0  input  1  opcode LSB
- in_valid  input  1  operands/opcode valid this cycle
- S  output  4  registered result
- CF  output  1  registered carry flag
- OF  output  1  registered signed-overflow flag
- out_valid  output  1  S/CF/OF updated by the previous cycle's accepted operation

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, independent of clk): S=4'b0000, CF=0, OF=0, out_valid=0. Takes effect immediately.
- On rst_n deassertion, the first capture occurs at the next rising clk edge.
- Latency: the combinational result is captured on the rising edge where in_valid=1.
  - S/CF/OF are visible the following cycle; out_valid=1 for exactly that cycle.
- in_valid=0: S/CF/OF hold their last values; out_valid=0 at that edge.
- No backpressure. Back-to-back in_valid produces back-to-back results.
- Opcode {OP1,OP0}:
  - 00 ADD:
    - Computation: 5-bit sum = A + B + CIN; S = sum[3:0]; CF = sum[4].
    - OF = 1 iff A[3]==B[3] and S[3]!=A[3].
  - 01 SUB:
    - Computation: S = A - B - CIN, implemented as A + ~B + !CIN; CF = carry-out of that sum (1 = no borrow).
    - OF = 1 iff A[3]!=B[3] and S[3]!=A[3].
  - 10 INC:
    - Computation: S = A + 1; CF = 1 iff A=4'b1111.
    - OF = 1 iff A=4'b0111. B and CIN are ignored.
  - 11 PASS: S = A; CF=0; OF=0. B and CIN are ignored.
- Wrap-around: all arithmetic is modulo 16; carry and overflow are reported only through the flags.
- X/Z on ignored inputs (B, CIN in INC/PASS) must not propagate to the outputs.

Decomposition:
- Package alu_pkg:
  - 2-bit opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_INC=2'b10, OP_PASS=2'b11.
  - Localparam WIDTH=4.
- One sub-module, alu_adder4:
  - 4-bit ripple-carry adder with ports a[3:0], b[3:0], cin, sum[3:0], cout, ovf.
  - Shared by ADD (b=B, cin=CIN), SUB (b=~B, cin=!CIN) and INC (b=0, cin=1).
- Top-level alu contains the opcode mux, the PASS path and the output registers.

Test Plan:
- ADD no carry: A=0011, B=0101, CIN=0, op=00 -> S=1000, CF=0, OF=1, out_valid=1 next cycle.
- ADD with carry wrap: A=1111, B=0001, CIN=1, op=00 -> S=0001, CF=1, OF=0.
- SUB: A=1000, B=0010, CIN=0, op=01 -> S=0110, CF=1, OF=1.
  - Also: A=0010, B=0011, CIN=1 -> S=1110, CF=0, OF=0.
- INC wrap: A=1111, op=10 -> S=0000, CF=1, OF=0.
  - Also: A=0111 -> S=1000, CF=0, OF=1.
- PASS: A=1010, B=X, op=11 -> S=1010, CF=0, OF=0.
  - Then in_valid=0 for 3 cycles -> S holds 1010, out_valid=0.
- Reset mid-stream: assert rst_n=0 between clk edges after a valid op -> S=0000, CF=0, OF=0, out_valid=0 immediately, without waiting for a clk edge.
